// File: rtl/vga_pkg.sv
// Shared VGA/frame-buffer constants, slot phase encodings and pixel type
// for the scan-out arbiter and its address generator.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int AW       = 15;
  localparam int DW       = 12;

  localparam logic [1:0] DISP_PHASE = 2'b01;
  localparam logic [1:0] CAP_PHASE  = 2'b10;
  localparam logic [1:0] LOAD_PHASE = 2'b11;

  typedef logic [DW-1:0] rgb_t;
endpackage

// File: rtl/vram_addr_gen.sv
// Combinational prefetch target: given the display-slot position h_pos=4k+1,
// returns the frame-buffer word for the block starting at 4k+4 and whether it is visible.
module vram_addr_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int FB_W     = 160,
  parameter int AW       = 15
) (
  input  logic [9:0]    i_h_pos,
  input  logic [9:0]    i_v_pos,
  output logic [AW-1:0] o_disp_addr,
  output logic          o_nxt_act
);
  logic [10:0] w_nh;
  logic [9:0]  w_line;
  logic [8:0]  w_x;

  assign w_nh = {1'b0, i_h_pos} + 11'd3;

  always_comb begin
    w_line    = i_v_pos;
    w_x       = w_nh[10:2];
    o_nxt_act = (i_v_pos < 10'(V_ACTIVE));
    if (w_nh >= 11'(H_ACTIVE)) begin
      // Past the visible width: aim at block 0 of the following line.
      w_line    = (i_v_pos == 10'(V_TOTAL - 1)) ? 10'd0 : i_v_pos + 10'd1;
      w_x       = 9'd0;
      o_nxt_act = (w_nh == 11'(H_TOTAL)) && (w_line < 10'(V_ACTIVE));
    end
  end

  assign o_disp_addr = AW'(w_line[9:2]) * AW'(FB_W) + AW'(w_x);
endmodule

// File: rtl/vram_scan_arbiter.sv
// Single-port frame-buffer arbiter: fixed display read slot at phase 01 of
// every 4-clock block, remaining slots granted to the host handshake port.
module vram_scan_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int FB_W     = 160,
  parameter int AW       = 15,
  parameter int DW       = 12
) (
  input  logic          clk_25MHz,
  input  logic          rst_,
  input  logic [9:0]    h_pos,
  input  logic [9:0]    v_pos,
  output logic [DW-1:0] rgb_out,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  import vga_pkg::*;

  logic [1:0]    w_phase;
  logic          w_disp_slot;
  logic          w_xfer;
  logic [AW-1:0] w_disp_addr;
  logic          w_nxt_act;

  logic          r_act_q;
  logic [DW-1:0] r_next_pix;
  logic [DW-1:0] r_rgb;
  logic          r_host_rvalid;

  vram_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .FB_W     (FB_W),
    .AW       (AW)
  ) u_addr_gen (
    .i_h_pos     (h_pos),
    .i_v_pos     (v_pos),
    .o_disp_addr (w_disp_addr),
    .o_nxt_act   (w_nxt_act)
  );

  assign w_phase     = h_pos[1:0];
  assign w_disp_slot = (w_phase == DISP_PHASE);
  assign host_ready  = rst_ & ~w_disp_slot;
  assign w_xfer      = host_valid & host_ready;

  // The display read is unconditional so the slot schedule never shifts.
  assign ram_en    = rst_ & (w_disp_slot | w_xfer);
  assign ram_we    = w_xfer & host_we;
  assign ram_addr  = w_disp_slot ? w_disp_addr : host_addr;
  assign ram_wdata = host_wdata;

  assign host_rdata  = ram_rdata;
  assign host_rvalid = r_host_rvalid;
  assign rgb_out     = r_rgb;

  always_ff @(posedge clk_25MHz or negedge rst_) begin
    if (!rst_) begin
      r_act_q       <= 1'b0;
      r_next_pix    <= '0;
      r_rgb         <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      // Only host reads can occupy a non-display slot, so the tag is just w_xfer & ~we.
      r_host_rvalid <= w_xfer & ~host_we;
      case (w_phase)
        DISP_PHASE: r_act_q    <= w_nxt_act;
        CAP_PHASE:  r_next_pix <= ram_rdata;
        LOAD_PHASE: r_rgb      <= r_act_q ? r_next_pix : '0;
        default: ;
      endcase
    end
  end
endmodule
